// File: rtl/tmma_pkg.sv
// -----------------------------------------------------------------------------
// tmma_pkg
// Shared types and widths for the TMMA sequencer slice.
//   Width macros (overridable at build time, defaults below):
//     TMMA_CNT_WIDTH        K count / beat index width
//     TMMA_PRECISION_WIDTH  precision field width
//     SARRAY_LOAD_WIDTH     edge operand beat width
//     SARRAY_STORE_WIDTH    bottom-edge result beat width
//   Contents: sequencer state enum, command struct, flush counter sizing.
// -----------------------------------------------------------------------------
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 32
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 32
`endif

package tmma_pkg;

  localparam int TMMA_CNT_W     = `TMMA_CNT_WIDTH;
  localparam int TMMA_PREC_W    = `TMMA_PRECISION_WIDTH;
  localparam int SARRAY_LOAD_W  = `SARRAY_LOAD_WIDTH;
  localparam int SARRAY_STORE_W = `SARRAY_STORE_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // One latched TMMA command.
  typedef struct packed {
    logic [TMMA_CNT_W-1:0]  k;
    logic                   acc;
    logic                   typ;
    logic [TMMA_PREC_W-1:0] prec;
  } tmma_cmd_t;

  // Flush counter must be able to hold FLUSH_CYC; never narrower than 1 bit.
  function automatic int flush_cnt_w(input int flush_cyc);
    return (flush_cyc < 1) ? 1 : $clog2(flush_cyc + 1);
  endfunction

endpackage

// File: rtl/sarray_seq_if.sv
// -----------------------------------------------------------------------------
// sarray_seq_if
// Issuer-side bundle of the sequencer: command handshake plus the left (a)
// and top (b) operand streams.
//   master : TMMA issue logic / operand buffers (drives valid, fields, data)
//   slave  : sarray_seq (drives cmd_ready, a_ready, b_ready)
// -----------------------------------------------------------------------------
interface sarray_seq_if #(
  parameter int CNT_W  = tmma_pkg::TMMA_CNT_W,
  parameter int PREC_W = tmma_pkg::TMMA_PREC_W,
  parameter int LOAD_W = tmma_pkg::SARRAY_LOAD_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_k;
  logic              cmd_acc;
  logic              cmd_type;
  logic [PREC_W-1:0] cmd_prec;

  logic              a_valid;
  logic              a_ready;
  logic [LOAD_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [LOAD_W-1:0] b_data;

  modport master (
    output cmd_valid, cmd_k, cmd_acc, cmd_type, cmd_prec,
    output a_valid, a_data, b_valid, b_data,
    input  cmd_ready, a_ready, b_ready
  );

  modport slave (
    input  cmd_valid, cmd_k, cmd_acc, cmd_type, cmd_prec,
    input  a_valid, a_data, b_valid, b_data,
    output cmd_ready, a_ready, b_ready
  );

endinterface

// File: rtl/sarray_seq_join.sv
// -----------------------------------------------------------------------------
// sarray_seq_join
// Joint valid/ready handshake of the left (a) and top (b) operand streams and
// the output register that presents each joined beat to the array edges.
//   clk, rst_n            clock, asynchronous active-low reset
//   feed_en_i             sequencer is in FEED
//   clr_i                 abort: drop the beat being registered this cycle
//   a_*/b_* valid/data    operand streams in; a_ready_o/b_ready_o out
//   fire_o                both streams consumed this cycle
//   step_i, acc_i, type_i, prec_i   beat index and latched command fields
//   left_in_* / top_in_*  registered array-edge outputs
// -----------------------------------------------------------------------------
module sarray_seq_join #(
  parameter int CNT_W  = tmma_pkg::TMMA_CNT_W,
  parameter int PREC_W = tmma_pkg::TMMA_PREC_W,
  parameter int LOAD_W = tmma_pkg::SARRAY_LOAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              feed_en_i,
  input  logic              clr_i,
  input  logic              a_valid_i,
  input  logic [LOAD_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [LOAD_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              fire_o,
  input  logic [CNT_W-1:0]  step_i,
  input  logic              acc_i,
  input  logic              type_i,
  input  logic [PREC_W-1:0] prec_i,
  output logic              left_in_valid_o,
  output logic [CNT_W-1:0]  left_in_cnt_o,
  output logic              left_in_type_o,
  output logic [PREC_W-1:0] left_in_precision_o,
  output logic [LOAD_W-1:0] left_in_data_o,
  output logic              top_in_valid_o,
  output logic              top_in_acc_o,
  output logic [CNT_W-1:0]  top_in_cnt_o,
  output logic [LOAD_W-1:0] top_in_data_o
);

  logic              beat_valid_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              beat_type_q;
  logic              beat_acc_q;
  logic [PREC_W-1:0] beat_prec_q;
  logic [LOAD_W-1:0] left_data_q;
  logic [LOAD_W-1:0] top_data_q;

  // Neither stream is taken alone: both readies depend on both valids.
  assign fire_o    = feed_en_i && a_valid_i && b_valid_i;
  assign a_ready_o = fire_o;
  assign b_ready_o = fire_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid_q <= 1'b0;
      beat_cnt_q   <= '0;
      beat_type_q  <= 1'b0;
      beat_acc_q   <= 1'b0;
      beat_prec_q  <= '0;
      left_data_q  <= '0;
      top_data_q   <= '0;
    end else begin
      beat_valid_q <= fire_o && !clr_i;
      if (fire_o) begin
        beat_cnt_q  <= step_i;
        beat_type_q <= type_i;
        beat_acc_q  <= acc_i;
        beat_prec_q <= prec_i;
        left_data_q <= a_data_i;
        top_data_q  <= b_data_i;
      end
    end
  end

  // Both edges always carry the same beat, so they share one valid/cnt.
  assign left_in_valid_o     = beat_valid_q;
  assign left_in_cnt_o       = beat_cnt_q;
  assign left_in_type_o      = beat_type_q;
  assign left_in_precision_o = beat_prec_q;
  assign left_in_data_o      = left_data_q;
  assign top_in_valid_o      = beat_valid_q;
  assign top_in_acc_o        = beat_acc_q;
  assign top_in_cnt_o        = beat_cnt_q;
  assign top_in_data_o       = top_data_q;

endmodule

// File: rtl/sarray_seq.sv
// -----------------------------------------------------------------------------
// sarray_seq
// Sequencer for one tile matrix-multiply on the systolic array: accepts a
// command, feeds K joined operand beats to the left/top edges, waits
// FLUSH_CYC cycles, pulses store-C, collects ARRAY_DIM bottom-edge result
// beats, then pulses done_o.
//   clk, rst_n                 clock, asynchronous active-low reset
//   seq_if (slave)             command handshake + a/b operand streams
//   abort_i                    synchronous abort (ignored in IDLE)
//   left_in_* / top_in_*       registered array-edge operand outputs
//   post_storec_valid_o        one-cycle store-C pulse
//   bot_valid_i/cnt_i/data_i   array bottom edge (used only in DRAIN)
//   res_valid_o/idx_o/data_o   registered result beats, index 0..ARRAY_DIM-1
//   busy_o, done_o             status; done_o is a one-cycle pulse
// Optional (SARRAY_SEQ_PERF_EN): perf_busy_cyc_o, perf_bubble_cyc_o,
//   32-bit saturating counters of busy cycles and FEED cycles without a fire.
// -----------------------------------------------------------------------------
module sarray_seq
  import tmma_pkg::*;
#(
  parameter int ARRAY_DIM = 64,
  parameter int CNT_W     = TMMA_CNT_W,
  parameter int PREC_W    = TMMA_PREC_W,
  parameter int LOAD_W    = SARRAY_LOAD_W,
  parameter int STORE_W   = SARRAY_STORE_W,
  parameter int FLUSH_CYC = 2 * ARRAY_DIM - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sarray_seq_if.slave        seq_if,
  input  logic               abort_i,
  output logic               left_in_valid_o,
  output logic [CNT_W-1:0]   left_in_cnt_o,
  output logic               left_in_type_o,
  output logic [PREC_W-1:0]  left_in_precision_o,
  output logic [LOAD_W-1:0]  left_in_data_o,
  output logic               top_in_valid_o,
  output logic               top_in_acc_o,
  output logic [CNT_W-1:0]   top_in_cnt_o,
  output logic [LOAD_W-1:0]  top_in_data_o,
  output logic               post_storec_valid_o,
  input  logic               bot_valid_i,
  input  logic [CNT_W-1:0]   bot_cnt_i,
  input  logic [STORE_W-1:0] bot_data_i,
  output logic               res_valid_o,
  output logic [CNT_W-1:0]   res_idx_o,
  output logic [STORE_W-1:0] res_data_o,
  output logic               busy_o,
  output logic               done_o
`ifdef SARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_busy_cyc_o,
  output logic [31:0]        perf_bubble_cyc_o
`endif
);

  localparam int FL_W = flush_cnt_w(FLUSH_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIM_LAST  = CNT_W'(ARRAY_DIM - 1);
  localparam logic [FL_W-1:0]  FL_ONE    = FL_W'(1);
  localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLUSH_CYC - 1);

  seq_state_e         state_q, state_d;
  tmma_cmd_t          cmd_q, cmd_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               storec_q, storec_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_W-1:0]   res_idx_q, res_idx_d;
  logic [STORE_W-1:0] res_data_q, res_data_d;

  logic fire;
  logic abort_act;

  // The array reports its own beat count; the running index is authoritative.
  logic unused_bot_cnt;
  assign unused_bot_cnt = ^bot_cnt_i;

  assign abort_act = abort_i && (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Operand join + array-edge output register
  // ---------------------------------------------------------------------------
  sarray_seq_join #(
    .CNT_W  (CNT_W),
    .PREC_W (PREC_W),
    .LOAD_W (LOAD_W)
  ) u_join (
    .clk                 (clk),
    .rst_n               (rst_n),
    .feed_en_i           (state_q == ST_FEED),
    .clr_i               (abort_act),
    .a_valid_i           (seq_if.a_valid),
    .a_data_i            (seq_if.a_data),
    .a_ready_o           (seq_if.a_ready),
    .b_valid_i           (seq_if.b_valid),
    .b_data_i            (seq_if.b_data),
    .b_ready_o           (seq_if.b_ready),
    .fire_o              (fire),
    .step_i              (step_q),
    .acc_i               (cmd_q.acc),
    .type_i              (cmd_q.typ),
    .prec_i              (cmd_q.prec),
    .left_in_valid_o     (left_in_valid_o),
    .left_in_cnt_o       (left_in_cnt_o),
    .left_in_type_o      (left_in_type_o),
    .left_in_precision_o (left_in_precision_o),
    .left_in_data_o      (left_in_data_o),
    .top_in_valid_o      (top_in_valid_o),
    .top_in_acc_o        (top_in_acc_o),
    .top_in_cnt_o        (top_in_cnt_o),
    .top_in_data_o       (top_in_data_o)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    step_d      = step_q;
    flush_d     = flush_q;
    beat_d      = beat_q;
    storec_d    = 1'b0;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (seq_if.cmd_valid) begin
          cmd_d   = '{k:    seq_if.cmd_k,
                      acc:  seq_if.cmd_acc,
                      typ:  seq_if.cmd_type,
                      prec: seq_if.cmd_prec};
          step_d  = '0;
          flush_d = '0;
          beat_d  = '0;
          // An empty command touches nothing on the array.
          state_d = (seq_if.cmd_k == '0) ? ST_DONE : ST_FEED;
        end
      end

      ST_FEED: begin
        if (fire) begin
          step_d = step_q + CNT_ONE;
          if (step_q == cmd_q.k - CNT_ONE) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // Counter enters at 0 on the cycle the last beat is on the edge;
        // the pulse is registered so it lands FLUSH_CYC cycles later.
        if (flush_q == FL_LAST) begin
          storec_d = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          flush_d = flush_q + FL_ONE;
        end
      end

      ST_DRAIN: begin
        if (bot_valid_i) begin
          res_valid_d = 1'b1;
          res_idx_d   = beat_q;
          res_data_d  = bot_data_i;
          beat_d      = beat_q + CNT_ONE;
          if (beat_q == DIM_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided.
    if (abort_act) begin
      state_d     = ST_IDLE;
      step_d      = '0;
      flush_d     = '0;
      beat_d      = '0;
      storec_d    = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      step_q      <= '0;
      flush_q     <= '0;
      beat_q      <= '0;
      storec_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      step_q      <= step_d;
      flush_q     <= flush_d;
      beat_q      <= beat_d;
      storec_q    <= storec_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
    end
  end

  assign seq_if.cmd_ready    = (state_q == ST_IDLE);
  assign busy_o              = (state_q != ST_IDLE);
  assign done_o              = (state_q == ST_DONE);
  assign post_storec_valid_o = storec_q;
  assign res_valid_o         = res_valid_q;
  assign res_idx_o           = res_idx_q;
  assign res_data_o          = res_data_q;

`ifdef SARRAY_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters: [0] busy cycles, [1] FEED bubbles.
  // ---------------------------------------------------------------------------
  logic [1:0] perf_inc;
  assign perf_inc[0] = busy_o;
  assign perf_inc[1] = (state_q == ST_FEED) && !fire;

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (perf_inc[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign perf_busy_cyc_o   = g_perf[0].cnt_q;
  assign perf_bubble_cyc_o = g_perf[1].cnt_q;
`endif

endmodule

// File: tb/tb_sarray_seq.sv
// -----------------------------------------------------------------------------
// tb_sarray_seq
// Self-checking bench for sarray_seq with ARRAY_DIM=4, FLUSH_CYC=7.
// Expected behaviour is derived from the operation's rules: beats are numbered
// in fire order, store-C lands FLUSH_CYC cycles after the last edge beat,
// results are indexed in arrival order, done follows the last result beat.
// -----------------------------------------------------------------------------
module tb_sarray_seq;

  localparam int DIM  = 4;
  localparam int FLC  = 7;
  localparam int CW   = tmma_pkg::TMMA_CNT_W;
  localparam int PW   = tmma_pkg::TMMA_PREC_W;
  localparam int LW   = tmma_pkg::SARRAY_LOAD_W;
  localparam int SW   = tmma_pkg::SARRAY_STORE_W;

  logic          clk;
  logic          rst_n;
  logic          abort_i;
  logic          left_in_valid_o;
  logic [CW-1:0] left_in_cnt_o;
  logic          left_in_type_o;
  logic [PW-1:0] left_in_precision_o;
  logic [LW-1:0] left_in_data_o;
  logic          top_in_valid_o;
  logic          top_in_acc_o;
  logic [CW-1:0] top_in_cnt_o;
  logic [LW-1:0] top_in_data_o;
  logic          post_storec_valid_o;
  logic          bot_valid_i;
  logic [CW-1:0] bot_cnt_i;
  logic [SW-1:0] bot_data_i;
  logic          res_valid_o;
  logic [CW-1:0] res_idx_o;
  logic [SW-1:0] res_data_o;
  logic          busy_o;
  logic          done_o;
`ifdef SARRAY_SEQ_PERF_EN
  logic [31:0]   perf_busy_cyc_o;
  logic [31:0]   perf_bubble_cyc_o;
`endif

  int checks   = 0;
  int failures = 0;
  int tb_bub   = 0;

  sarray_seq_if #(.CNT_W(CW), .PREC_W(PW), .LOAD_W(LW)) sif ();

  sarray_seq #(
    .ARRAY_DIM (DIM),
    .CNT_W     (CW),
    .PREC_W    (PW),
    .LOAD_W    (LW),
    .STORE_W   (SW),
    .FLUSH_CYC (FLC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .seq_if              (sif),
    .abort_i             (abort_i),
    .left_in_valid_o     (left_in_valid_o),
    .left_in_cnt_o       (left_in_cnt_o),
    .left_in_type_o      (left_in_type_o),
    .left_in_precision_o (left_in_precision_o),
    .left_in_data_o      (left_in_data_o),
    .top_in_valid_o      (top_in_valid_o),
    .top_in_acc_o        (top_in_acc_o),
    .top_in_cnt_o        (top_in_cnt_o),
    .top_in_data_o       (top_in_data_o),
    .post_storec_valid_o (post_storec_valid_o),
    .bot_valid_i         (bot_valid_i),
    .bot_cnt_i           (bot_cnt_i),
    .bot_data_i          (bot_data_i),
    .res_valid_o         (res_valid_o),
    .res_idx_o           (res_idx_o),
    .res_data_o          (res_data_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
`ifdef SARRAY_SEQ_PERF_EN
    ,
    .perf_busy_cyc_o     (perf_busy_cyc_o),
    .perf_bubble_cyc_o   (perf_bubble_cyc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation. Options: gap_at/gap_len hold b_valid low for a window
  // of FEED cycles; rnd randomises both valids; abort_at aborts at that flush
  // count; rst_after asserts async reset after that many result beats; b2b
  // presents a k=1 command while done_o is high.
  task automatic run_cmd(input int k, input bit acc, input bit typ, input logic [PW-1:0] prec,
                         input int gap_at, input int gap_len, input bit rnd,
                         input int abort_at, input int rst_after, input bit b2b);
    int fed, bub, fc, gaps;
    bit pend, av, bv;
    logic [CW-1:0] exp_cnt;
    logic [LW-1:0] exp_a, exp_b, a_beat, b_beat;
    logic [SW-1:0] r_beat;

    sif.cmd_k    = CW'(k);
    sif.cmd_acc  = acc;
    sif.cmd_type = typ;
    sif.cmd_prec = prec;
    sif.cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", sif.cmd_ready, 1'b1);
    tick();
    sif.cmd_valid = 1'b0;

    // FEED: beats are numbered in the order the joint handshake fires.
    fed = 0; bub = 0; fc = 0; pend = 1'b0;
    exp_cnt = '0; exp_a = '0; exp_b = '0;
    for (int guard = 0; guard <= 400; guard++) begin
      chk("left_valid", left_in_valid_o, pend);
      chk("top_valid", top_in_valid_o, pend);
      chk("busy_feed", busy_o, 1'b1);
      if (pend) begin
        chk("left_cnt", left_in_cnt_o, exp_cnt);
        chk("top_cnt", top_in_cnt_o, exp_cnt);
        chk("left_data", left_in_data_o, exp_a);
        chk("top_data", top_in_data_o, exp_b);
        chk("left_type", left_in_type_o, typ);
        chk("left_prec", left_in_precision_o, prec);
        chk("top_acc", top_in_acc_o, acc);
      end
      if (fed == k) break;
      if (guard == 400) begin
        checks++;
        failures++;
        $error("FAIL feed_timeout: observed fed=%0d expected fed=%0d", fed, k);
        return;
      end
      if (rnd) begin
        av = ($urandom_range(0, 3) != 0);
        bv = ($urandom_range(0, 3) != 0);
      end else begin
        av = 1'b1;
        bv = !(gap_at >= 0 && fc >= gap_at && fc < gap_at + gap_len);
      end
      a_beat = $urandom;
      b_beat = $urandom;
      sif.a_valid = av;
      sif.b_valid = bv;
      sif.a_data  = a_beat;
      sif.b_data  = b_beat;
      #1;
      chk("a_ready", sif.a_ready, av && bv);
      chk("b_ready", sif.b_ready, av && bv);
      pend = av && bv;
      if (pend) begin
        exp_cnt = CW'(fed);
        exp_a   = a_beat;
        exp_b   = b_beat;
        fed++;
      end else begin
        bub++;
      end
      fc++;
      tick();
    end
    sif.a_valid = 1'b0;
    sif.b_valid = 1'b0;
    tb_bub += bub;
`ifdef SARRAY_SEQ_PERF_EN
    chk("perf_bubble", perf_bubble_cyc_o, tb_bub);
`endif

    // FLUSH: cycle j of the flush window has flush count j.
    for (int j = 0; j < FLC; j++) begin
      if (j == abort_at) begin
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_cmd_ready", sif.cmd_ready, 1'b1);
        chk("abort_storec", post_storec_valid_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        for (int q = 0; q < 10; q++) begin
          tick();
          chk("abort_storec_later", post_storec_valid_o, 1'b0);
          chk("abort_done_later", done_o, 1'b0);
        end
        return;
      end
      tick();
      chk("storec", post_storec_valid_o, j == FLC - 1);
      chk("flush_left_valid", left_in_valid_o, 1'b0);
    end

    // DRAIN: result index follows arrival order of bottom beats.
    for (int idx = 0; idx < DIM; idx++) begin
      gaps = rnd ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        tick();
        chk("drain_gap_res_valid", res_valid_o, 1'b0);
        chk("drain_gap_done", done_o, 1'b0);
      end
      r_beat = $urandom;
      bot_valid_i = 1'b1;
      bot_cnt_i   = CW'(idx);
      bot_data_i  = r_beat;
      tick();
      bot_valid_i = 1'b0;
      chk("res_valid", res_valid_o, 1'b1);
      chk("res_idx", res_idx_o, CW'(idx));
      chk("res_data", res_data_o, r_beat);
      chk("res_done", done_o, idx == DIM - 1);
      chk("drain_storec", post_storec_valid_o, 1'b0);
      if (idx + 1 == rst_after) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_ready", sif.cmd_ready, 1'b1);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_res_valid", res_valid_o, 1'b0);
        chk("arst_res_idx", res_idx_o, '0);
        chk("arst_res_data", res_data_o, '0);
        chk("arst_done", done_o, 1'b0);
        chk("arst_storec", post_storec_valid_o, 1'b0);
        chk("arst_left_valid", left_in_valid_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tb_bub = 0;
        tick();
        chk("arst_release_ready", sif.cmd_ready, 1'b1);
        return;
      end
    end

    // DONE cycle.
    chk("done_busy", busy_o, 1'b1);
    if (b2b) begin
      sif.cmd_k     = CW'(1);
      sif.cmd_acc   = 1'b0;
      sif.cmd_type  = 1'b0;
      sif.cmd_prec  = '0;
      sif.cmd_valid = 1'b1;
    end
    #1;
    chk("cmd_ready_done", sif.cmd_ready, 1'b0);
    tick();
    chk("done_pulse_end", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_cmd_ready", sif.cmd_ready, 1'b1);
    chk("idle_res_valid", res_valid_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    abort_i = 1'b0;
    sif.cmd_valid = 1'b0;
    sif.cmd_k = '0;
    sif.cmd_acc = 1'b0;
    sif.cmd_type = 1'b0;
    sif.cmd_prec = '0;
    sif.a_valid = 1'b1;
    sif.b_valid = 1'b1;
    sif.a_data = '0;
    sif.b_data = '0;
    bot_valid_i = 1'b0;
    bot_cnt_i = '0;
    bot_data_i = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", sif.cmd_ready, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_left_valid", left_in_valid_o, 1'b0);
    chk("rst_top_valid", top_in_valid_o, 1'b0);
    chk("rst_storec", post_storec_valid_o, 1'b0);
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_a_ready", sif.a_ready, 1'b0);
    chk("rst_left_data", left_in_data_o, '0);
    sif.a_valid = 1'b0;
    sif.b_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // k=3, acc=1, streams always valid.
    run_cmd(3, 1'b1, 1'b0, PW'(1), -1, 0, 1'b0, -1, -1, 1'b0);

    // Same with b_valid low for two FEED cycles mid-stream.
    run_cmd(3, 1'b1, 1'b0, PW'(1), 1, 2, 1'b0, -1, -1, 1'b0);

    // k=0 (with abort_i in IDLE, which must not block acceptance).
    sif.cmd_k = '0;
    sif.cmd_valid = 1'b1;
    abort_i = 1'b1;
    #1;
    chk("k0_cmd_ready", sif.cmd_ready, 1'b1);
    tick();
    sif.cmd_valid = 1'b0;
    abort_i = 1'b0;
    chk("k0_done", done_o, 1'b1);
    chk("k0_busy", busy_o, 1'b1);
    chk("k0_left_valid", left_in_valid_o, 1'b0);
    chk("k0_storec", post_storec_valid_o, 1'b0);
    chk("k0_cmd_ready_done", sif.cmd_ready, 1'b0);
    tick();
    chk("k0_done_end", done_o, 1'b0);
    chk("k0_busy_end", busy_o, 1'b0);
    chk("k0_left_valid_end", left_in_valid_o, 1'b0);

    // Randomised commands.
    for (int r = 0; r < 4; r++) begin
      run_cmd($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              PW'($urandom), -1, 0, 1'b1, -1, -1, 1'b0);
    end

    // Abort in FLUSH at count 3.
    run_cmd(2, 1'b0, 1'b1, PW'(2), -1, 0, 1'b0, 3, -1, 1'b0);

    // bot_valid_i while IDLE is ignored.
    for (int p = 0; p < 2; p++) begin
      bot_valid_i = 1'b1;
      bot_data_i  = $urandom;
      tick();
      chk("idle_bot_res_valid", res_valid_o, 1'b0);
    end
    bot_valid_i = 1'b0;
    tick();
    chk("idle_bot_res_valid_end", res_valid_o, 1'b0);

    // Command held during DONE is accepted only the cycle after done_o.
    run_cmd(2, 1'b1, 1'b1, PW'(3), -1, 0, 1'b0, -1, -1, 1'b1);
    run_cmd(1, 1'b0, 1'b0, PW'(0), -1, 0, 1'b0, -1, -1, 1'b0);

    // Async reset in DRAIN after two beats, then a fresh k=1 command.
    run_cmd(2, 1'b1, 1'b1, PW'(3), -1, 0, 1'b0, -1, 2, 1'b0);
    run_cmd(1, 1'b1, 1'b0, PW'(1), -1, 0, 1'b0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sarray_seq.md
Name: sarray_seq

Overview:
- Sequencer for one tile matrix-multiply (TMMA) on the 64x64 systolic array.
- Accepts one command per operation and feeds K operand beats on the left and top array edges together.
- Waits for the array pipeline to fill, pulses store-C, then collects the ARRAY_DIM result beats from the bottom edge.
- Sits between the TMMA issue logic / operand buffers and the sarray instance.

Parameters:
- ARRAY_DIM, 64: PE rows/cols; number of result beats expected per drain.
- CNT_W, `TMMA_CNT_WIDTH: width of K count and beat index.
- PREC_W, `TMMA_PRECISION_WIDTH: precision field width.
- LOAD_W, `SARRAY_LOAD_WIDTH: edge operand beat width.
- STORE_W, `SARRAY_STORE_WIDTH: bottom result beat width.
- FLUSH_CYC, 2*ARRAY_DIM-1: cycles from last feed beat to store-C pulse.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_k_i  in  CNT_W  number of K beats
- cmd_acc_i  in  1  accumulate into existing C
- cmd_type_i  in  1  operand type
- cmd_prec_i  in  PREC_W  precision
- abort_i  in  1  synchronous abort
- a_valid_i / a_ready_o / a_data_i  in/out/in  1/1/LOAD_W  left operand stream
- b_valid_i / b_ready_o / b_data_i  in/out/in  1/1/LOAD_W  top operand stream
- left_in_valid_o, left_in_cnt_o, left_in_type_o, left_in_precision_o, left_in_data_o  out  1/CNT_W/1/PREC_W/LOAD_W  to array left edge
- top_in_valid_o, top_in_acc_o, top_in_cnt_o, top_in_data_o  out  1/1/CNT_W/LOAD_W  to array top edge
- post_storec_valid_o  out  1  store-C pulse
- bot_valid_i, bot_cnt_i, bot_data_i  in  1/CNT_W/STORE_W  from array bottom edge
- res_valid_o, res_idx_o, res_data_o  out  1/CNT_W/STORE_W  result beats
- busy_o, done_o  out  1  status; done_o is a 1-cycle pulse

Behaviour:
- Reset: state IDLE; every output 0 except cmd_ready_o=1. All array-facing outputs are registered.
- IDLE: cmd_ready_o=1. Command accepted on cmd_valid_i at cycle T; fields latched; step counter cleared.
  - k=0: go to DONE (done_o at T+1), with no array activity.
  - Otherwise go to FEED.
- FEED:
  - a_ready_o = b_ready_o = (state==FEED) && a_valid_i && b_valid_i. The joint handshake means neither stream is consumed alone.
  - On a fire, the cycle after drives left_in_valid_o = top_in_valid_o = 1, cnt = step, data = a/b beat, type/prec/acc = latched values. Step increments.
  - If a fire does not occur, both valids are 0 (bubble); the array tolerates bubbles.
  - After beat k-1 fires, go to FLUSH.
- FLUSH: counter runs FLUSH_CYC cycles, then post_storec_valid_o=1 for exactly one cycle and state goes to DRAIN.
- DRAIN:
  - Each bot_valid_i is registered to res_valid_o with res_idx_o = running beat index (0..ARRAY_DIM-1) and res_data_o = bot_data_i. There is no backpressure.
  - bot_valid_i outside DRAIN is ignored.
  - After beat ARRAY_DIM-1, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. cmd_ready_o=0 in DONE, so a back-to-back command is accepted at earliest the cycle after done_o.
- busy_o = (state != IDLE).
- abort_i:
  - In any non-IDLE state: next state IDLE, all counters cleared, array valids and storec forced 0 next cycle, no done_o.
  - abort_i in IDLE is ignored. abort_i and cmd_valid_i together in IDLE: the command is accepted.
- Async reset mid-operation: immediate return to reset values. Partially fed data in the array is discarded by the issuer.
- Counter widths: the step counter is CNT_W bits; cmd_k_i max 2^CNT_W-1, with no wrap. The FLUSH counter is sized $clog2(FLUSH_CYC+1).

Optional Feature:
- Macro SARRAY_SEQ_PERF_EN.
- Defined: adds outputs perf_busy_cyc_o and perf_bubble_cyc_o (32b, saturating).
  - perf_busy_cyc_o counts cycles with busy_o=1.
  - perf_bubble_cyc_o counts FEED cycles without a fire.
  - Both clear on reset only.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package tmma_pkg holds:
  - state enum (IDLE, FEED, FLUSH, DRAIN, DONE);
  - the width macros reused as localparams;
  - the command struct {k, acc, type, prec}.
- One natural sub-module, sarray_seq_join: the 2-stream joint valid/ready handshake plus output register for left/top beats.

Test Plan:
- ARRAY_DIM=4, FLUSH_CYC=7, cmd k=3, acc=1, both streams always valid:
  - left/top valid on 3 consecutive cycles with cnt 0,1,2;
  - post_storec_valid_o 7 cycles after the last feed;
  - 4 bot beats give res_idx 0..3;
  - done_o one cycle after idx 3.
- Same command with b_valid_i low for 2 cycles mid-stream: no a beat consumed during the gap, 2 bubbles, cnt still 0,1,2. Perf build shows bubble counter = 2.
- k=0 command: done_o at T+1, no left/top/storec activity, busy_o high for 1 cycle.
- abort_i asserted in FLUSH at counter=3: no storec pulse, no done_o, busy_o low next cycle, cmd_ready_o=1.
- bot_valid_i pulsed while IDLE: no res_valid_o. Second command presented during DONE: accepted only the cycle after done_o.
- rst_n deasserted asynchronously in DRAIN after 2 beats: all outputs 0 immediately, cmd_ready_o=1 after release, a fresh k=1 command completes normally.
